ddr3_ps_ctrl: RTL

DDR3_PS_CTRL -- requirements
Module: ddr3_ps_ctrl

---
 rtl/ddr3_ps_ctrl_if.sv | 33 +++
 rtl/ddr3_ps_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ddr3_ps_ctrl_if.sv
// ============================================================================
// Module   : ddr3_ps_ctrl_if
// Brief    : Request/status and MMCM dynamic phase-shift signals of ddr3_ps_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ddr3_ps_ctrl_if;
  logic               ps_req;
  logic               ps_dir;
  logic [9:0]         ps_steps;
  logic               PSEN;
  logic               PSINCDEC;
  logic               PSDONE;
  logic               ps_busy;
  logic               ps_done;
  logic               ps_limit;
  logic               ps_err;
  logic signed [15:0] ps_offset;

  // master: application plus MMCM side; slave: the controller
  modport master (
    output ps_req, ps_dir, ps_steps, PSDONE,
    input  PSEN, PSINCDEC, ps_busy, ps_done, ps_limit, ps_err, ps_offset
  );

  modport slave (
    input  ps_req, ps_dir, ps_steps, PSDONE,
    output PSEN, PSINCDEC, ps_busy, ps_done, ps_limit, ps_err, ps_offset
  );
endinterface

`default_nettype wire

// File: rtl/ddr3_ps_ctrl.sv
// ============================================================================
// Module   : ddr3_ps_ctrl
// Brief    : MMCM fine phase-shift sequencer with offset tracking and limit.
//            Optional PSDONE timeout abort enabled by macro DDR3_PS_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_ps_ctrl #(
  parameter int MAX_OFFSET     = 560,
  parameter int TIMEOUT_CYCLES = 63
) (
  input  wire logic         clk_app,
  input  wire logic         rstdiv0,
  ddr3_ps_ctrl_if.slave     ps
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic signed [16:0] MAX_S = MAX_OFFSET[16:0];

  state_t             state;
  state_t             state_nx;
  logic               dir_r;
  logic [9:0]         remaining;
  logic signed [15:0] offset;
  logic               limit;
  logic               err;
  logic               done_q;
  logic               psdone_seen;
  logic               psen;
  logic               accept;
  logic               step_ok;
  logic               set_limit;
  logic               timeout_hit;
  logic signed [16:0] next_off;
  logic               over;

  assign next_off = {offset[15], offset} + (dir_r ? 17'sd1 : -17'sd1);
  assign over     = (next_off > MAX_S) || (next_off < -MAX_S);

  always_comb begin
    state_nx  = state;
    psen      = 1'b0;
    accept    = 1'b0;
    step_ok   = 1'b0;
    set_limit = 1'b0;
    case (state)
      IDLE: begin
        if (ps.ps_req) begin
          accept   = 1'b1;
          state_nx = (ps.ps_steps == 10'd0) ? DONE : STEP;
        end
      end
      STEP: begin
        if (remaining == 10'd0) begin
          state_nx = DONE;
        end else if (over) begin
          set_limit = 1'b1;
          state_nx  = DONE;
        end else begin
          psen     = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        // PSDONE is captured first so the next PSEN is two cycles after it
        if (psdone_seen) begin
          step_ok  = 1'b1;
          state_nx = STEP;
        end else if (timeout_hit) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_app or posedge rstdiv0) begin
    if (rstdiv0) begin
      state       <= IDLE;
      dir_r       <= 1'b0;
      remaining   <= 10'd0;
      offset      <= 16'sd0;
      limit       <= 1'b0;
      done_q      <= 1'b0;
      psdone_seen <= 1'b0;
    end else begin
      state       <= state_nx;
      done_q      <= (state == DONE);
      psdone_seen <= (state == WAIT) && !psdone_seen && ps.PSDONE;
      if (accept) begin
        dir_r     <= ps.ps_dir;
        remaining <= ps.ps_steps;
        limit     <= 1'b0;
      end else if (step_ok) begin
        offset    <= offset + (dir_r ? 16'sd1 : -16'sd1);
        remaining <= remaining - 10'd1;
      end
      if (set_limit) begin
        limit <= 1'b1;
      end
    end
  end

`ifdef DDR3_PS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] timer;

  // timer holds the number of WAIT cycles already elapsed
  assign timeout_hit = !ps.PSDONE && (timer == TO_LAST);

  always_ff @(posedge clk_app or posedge rstdiv0) begin
    if (rstdiv0) begin
      timer <= 8'd0;
      err   <= 1'b0;
    end else begin
      if (psen) begin
        timer <= 8'd0;
      end else if (state == WAIT) begin
        timer <= timer + 8'd1;
      end
      if (accept) begin
        err <= 1'b0;
      end else if ((state == WAIT) && !psdone_seen && timeout_hit) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign ps.PSEN      = psen;
  assign ps.PSINCDEC  = dir_r;
  assign ps.ps_busy   = (state != IDLE);
  assign ps.ps_done   = done_q;
  assign ps.ps_limit  = limit;
  assign ps.ps_err    = err;
  assign ps.ps_offset = offset;

endmodule

`default_nettype wire
